// File: rtl/rob_pkg.sv
// Shared widths, entry layout and pointer types for the reorder buffer.
package rob_pkg;

  localparam int unsigned Depth      = 16;
  localparam int unsigned PtrW       = 4;
  localparam int unsigned PcLength   = 32;
  localparam int unsigned DataLength = 32;
  localparam int unsigned RegLength  = 5;

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [PcLength-1:0]   pc;
    logic [RegLength-1:0]  rd;
    logic [DataLength-1:0] data;
    logic                  mispredict;
    logic [PcLength-1:0]   target;
  } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Decoder, CDB and register-file/fetch signals of the reorder buffer.
interface rob_if;
  import rob_pkg::*;

  logic                  is_empty_from_decoder;
  logic [PcLength-1:0]   pc_from_decoder;
  logic [RegLength-1:0]  rd_from_decoder;
  logic                  is_full_to_decoder;

  logic                  is_valid_from_cdb;
  logic [PcLength-1:0]   pc_from_cdb;
  logic [DataLength-1:0] data_from_cdb;
  logic                  is_mispredict_from_cdb;
  logic [PcLength-1:0]   target_from_cdb;

  logic                  is_commit_to_rf;
  logic                  is_exception_to_rf;
  logic [PcLength-1:0]   pc_to_rf;
  logic [RegLength-1:0]  rd_to_rf;
  logic [DataLength-1:0] data_to_rf;
  logic [PcLength-1:0]   pc_to_fetch;

  modport master (
    output is_empty_from_decoder, pc_from_decoder, rd_from_decoder,
    output is_valid_from_cdb, pc_from_cdb, data_from_cdb, is_mispredict_from_cdb,
    output target_from_cdb,
    input  is_full_to_decoder, is_commit_to_rf, is_exception_to_rf, pc_to_rf, rd_to_rf,
    input  data_to_rf, pc_to_fetch
  );

  modport slave (
    input  is_empty_from_decoder, pc_from_decoder, rd_from_decoder,
    input  is_valid_from_cdb, pc_from_cdb, data_from_cdb, is_mispredict_from_cdb,
    input  target_from_cdb,
    output is_full_to_decoder, is_commit_to_rf, is_exception_to_rf, pc_to_rf, rd_to_rf,
    output data_to_rf, pc_to_fetch
  );

endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, CDB capture by PC tag, in-order registered commit,
// full flush on a mispredicted branch reaching the head.
module rob
  import rob_pkg::*;
(
  input logic clk,
  input logic rst,
  rob_if.slave bus
);

  localparam cnt_t DepthCnt = cnt_t'(Depth);

  rob_entry_t entries_q [Depth];
  rob_entry_t entries_d [Depth];
  ptr_t       head_q, head_d, tail_q, tail_d;
  cnt_t       count_q, count_d;

  logic                  commit_q, commit_d;
  logic                  exception_q, exception_d;
  logic [PcLength-1:0]   pc_q, pc_d;
  logic [RegLength-1:0]  rd_q, rd_d;
  logic [DataLength-1:0] data_q, data_d;
  logic [PcLength-1:0]   fetch_q, fetch_d;

  logic       do_commit, do_flush, do_alloc, cdb_hit;
  ptr_t       cdb_idx;
  logic [PtrW:0] match;

  // Scan youngest to oldest so the last hit kept is the one nearest head.
  function automatic logic [PtrW:0] oldest_match(input rob_entry_t ents [Depth],
                                                 input ptr_t head,
                                                 input logic [PcLength-1:0] tag);
    logic [PtrW:0] res;
    ptr_t          idx;
    res = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      idx = head + ptr_t'(i);
      if (ents[idx].busy && !ents[idx].ready && (ents[idx].pc == tag)) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  always_comb begin
    entries_d   = entries_q;
    head_d      = head_q;
    tail_d      = tail_q;
    commit_d    = 1'b0;
    exception_d = 1'b0;
    pc_d        = pc_q;
    rd_d        = rd_q;
    data_d      = data_q;
    fetch_d     = fetch_q;

    do_commit = entries_q[head_q].busy && entries_q[head_q].ready;
    do_flush  = do_commit && entries_q[head_q].mispredict;
    do_alloc  = !bus.is_empty_from_decoder && (count_q < DepthCnt) && !do_flush;

    match   = oldest_match(entries_q, head_q, bus.pc_from_cdb);
    cdb_hit = match[PtrW];
    cdb_idx = match[PtrW-1:0];

    if (bus.is_valid_from_cdb && cdb_hit && !do_flush) begin
      entries_d[cdb_idx].ready      = 1'b1;
      entries_d[cdb_idx].data       = bus.data_from_cdb;
      entries_d[cdb_idx].mispredict = bus.is_mispredict_from_cdb;
      entries_d[cdb_idx].target     = bus.target_from_cdb;
    end

    if (do_alloc) begin
      entries_d[tail_q].busy       = 1'b1;
      entries_d[tail_q].ready      = 1'b0;
      entries_d[tail_q].pc         = bus.pc_from_decoder;
      entries_d[tail_q].rd         = bus.rd_from_decoder;
      entries_d[tail_q].data       = '0;
      entries_d[tail_q].mispredict = 1'b0;
      entries_d[tail_q].target     = '0;
      tail_d                       = tail_q + ptr_t'(1);
    end

    if (do_commit) begin
      entries_d[head_q].busy = 1'b0;
      head_d                 = head_q + ptr_t'(1);
      commit_d               = 1'b1;
      pc_d                   = entries_q[head_q].pc;
      rd_d                   = entries_q[head_q].rd;
      data_d                 = entries_q[head_q].data;
    end

    count_d = count_q + cnt_t'(do_alloc) - cnt_t'(do_commit);

    if (do_flush) begin
      exception_d = 1'b1;
      fetch_d     = entries_q[head_q].target;
      for (int i = 0; i < Depth; i++) begin
        entries_d[i].busy = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q   <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      commit_q    <= 1'b0;
      exception_q <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      fetch_q     <= '0;
    end else begin
      entries_q   <= entries_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      commit_q    <= commit_d;
      exception_q <= exception_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      fetch_q     <= fetch_d;
    end
  end

  assign bus.is_full_to_decoder = (count_q == DepthCnt);
  assign bus.is_commit_to_rf    = commit_q;
  assign bus.is_exception_to_rf = exception_q;
  assign bus.pc_to_rf           = pc_q;
  assign bus.rd_to_rf           = rd_q;
  assign bus.data_to_rf         = data_q;
  assign bus.pc_to_fetch        = fetch_q;

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for the reorder buffer.
module tb_rob;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rob_if bus ();

  rob dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.is_empty_from_decoder  = 1'b1;
    bus.pc_from_decoder        = '0;
    bus.rd_from_decoder        = '0;
    bus.is_valid_from_cdb      = 1'b0;
    bus.pc_from_cdb            = '0;
    bus.data_from_cdb          = '0;
    bus.is_mispredict_from_cdb = 1'b0;
    bus.target_from_cdb        = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd);
    bus.is_empty_from_decoder = 1'b0;
    bus.pc_from_decoder       = pc;
    bus.rd_from_decoder       = rd;
  endtask

  task automatic no_issue();
    bus.is_empty_from_decoder = 1'b1;
  endtask

  task automatic cdb(input logic [31:0] pc, input logic [31:0] data, input logic mp,
                     input logic [31:0] target);
    bus.is_valid_from_cdb      = 1'b1;
    bus.pc_from_cdb            = pc;
    bus.data_from_cdb          = data;
    bus.is_mispredict_from_cdb = mp;
    bus.target_from_cdb        = target;
  endtask

  task automatic no_cdb();
    bus.is_valid_from_cdb      = 1'b0;
    bus.is_mispredict_from_cdb = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #1;
    checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
      $display("FAIL reset_commit got=%b exp=0", bus.is_commit_to_rf); end
    checks++; if (bus.is_exception_to_rf !== 1'b0) begin errors++;
      $display("FAIL reset_exception got=%b exp=0", bus.is_exception_to_rf); end
    checks++; if (bus.is_full_to_decoder !== 1'b0) begin errors++;
      $display("FAIL reset_full got=%b exp=0", bus.is_full_to_decoder); end
    checks++; if ({bus.pc_to_rf, bus.data_to_rf, bus.pc_to_fetch, bus.rd_to_rf} !== '0) begin
      errors++; $display("FAIL reset_outputs pc=%h data=%h fetch=%h rd=%h exp=0",
                         bus.pc_to_rf, bus.data_to_rf, bus.pc_to_fetch, bus.rd_to_rf); end
    step();
    rst = 1'b1;
  endtask

  // Fill to 16 entries, drop a 17th, retire two out-of-order completions, refill to full.
  task automatic test_fill_and_retire();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(32'(4 * (i + 1)), 5'(i + 1));
      step();
      checks++; if (bus.is_full_to_decoder !== (i == 15)) begin errors++;
        $display("FAIL fill_full i=%0d got=%b exp=%b", i, bus.is_full_to_decoder, i == 15); end
      checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
        $display("FAIL fill_commit i=%0d got=%b exp=0", i, bus.is_commit_to_rf); end
    end
    issue(32'h44, 5'd17);
    step();
    checks++; if (bus.is_full_to_decoder !== 1'b1) begin errors++;
      $display("FAIL fill_17th_full got=%b exp=1", bus.is_full_to_decoder); end
    no_issue();
    cdb(32'h8, 32'h11, 1'b0, 32'h0);
    step();
    cdb(32'h4, 32'h22, 1'b0, 32'h0);
    step();
    no_cdb();
    checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
      $display("FAIL retire_early got=%b exp=0", bus.is_commit_to_rf); end
    step();
    checks++; if ({bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf, bus.rd_to_rf}
                  !== {1'b1, 32'h4, 32'h22, 5'd1}) begin errors++;
      $display("FAIL retire_first commit=%b pc=%h data=%h rd=%0d exp 1/4/22/1",
               bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf, bus.rd_to_rf); end
    checks++; if (bus.is_full_to_decoder !== 1'b0) begin errors++;
      $display("FAIL retire_not_full got=%b exp=0", bus.is_full_to_decoder); end
    step();
    checks++; if ({bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf, bus.rd_to_rf}
                  !== {1'b1, 32'h8, 32'h11, 5'd2}) begin errors++;
      $display("FAIL retire_second commit=%b pc=%h data=%h rd=%0d exp 1/8/11/2",
               bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf, bus.rd_to_rf); end
    step();
    checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
      $display("FAIL retire_stop got=%b exp=0", bus.is_commit_to_rf); end
    checks++; if (bus.pc_to_rf !== 32'h8) begin errors++;
      $display("FAIL retire_hold_pc got=%h exp=8", bus.pc_to_rf); end
    issue(32'h48, 5'd18);
    step();
    checks++; if (bus.is_full_to_decoder !== 1'b0) begin errors++;
      $display("FAIL refill_15 got=%b exp=0", bus.is_full_to_decoder); end
    issue(32'h4C, 5'd19);
    step();
    checks++; if (bus.is_full_to_decoder !== 1'b1) begin errors++;
      $display("FAIL refill_16 got=%b exp=1", bus.is_full_to_decoder); end
    no_issue();
  endtask

  task automatic test_mispredict();
    do_reset();
    issue(32'h10, 5'd3);  step();
    issue(32'h14, 5'd4);  step();
    issue(32'h18, 5'd5);  step();
    issue(32'h1C, 5'd6);  step();
    no_issue();
    cdb(32'h14, 32'h1, 1'b0, 32'h0);   step();
    cdb(32'h18, 32'h2, 1'b0, 32'h0);   step();
    cdb(32'h10, 32'h3, 1'b1, 32'h100); step();
    checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
      $display("FAIL mp_early got=%b exp=0", bus.is_commit_to_rf); end
    issue(32'h200, 5'd7);
    cdb(32'h1C, 32'h9, 1'b0, 32'h0);
    step();
    idle();
    checks++; if ({bus.is_commit_to_rf, bus.is_exception_to_rf, bus.pc_to_rf, bus.rd_to_rf}
                  !== {1'b1, 1'b1, 32'h10, 5'd3}) begin errors++;
      $display("FAIL mp_commit commit=%b exc=%b pc=%h rd=%0d exp 1/1/10/3",
               bus.is_commit_to_rf, bus.is_exception_to_rf, bus.pc_to_rf, bus.rd_to_rf); end
    checks++; if (bus.pc_to_fetch !== 32'h100) begin errors++;
      $display("FAIL mp_target got=%h exp=100", bus.pc_to_fetch); end
    step();
    checks++; if ({bus.is_commit_to_rf, bus.is_exception_to_rf} !== 2'b00) begin errors++;
      $display("FAIL mp_pulse commit=%b exc=%b exp 0/0",
               bus.is_commit_to_rf, bus.is_exception_to_rf); end
    checks++; if (bus.pc_to_fetch !== 32'h100) begin errors++;
      $display("FAIL mp_fetch_hold got=%h exp=100", bus.pc_to_fetch); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
        $display("FAIL mp_younger i=%0d pc=%h exp no commit", i, bus.pc_to_rf); end
    end
    issue(32'h300, 5'd8); step();
    no_issue();
    cdb(32'h300, 32'h33, 1'b0, 32'h0); step();
    no_cdb();
    step();
    checks++; if ({bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf}
                  !== {1'b1, 32'h300, 32'h33}) begin errors++;
      $display("FAIL mp_after commit=%b pc=%h data=%h exp 1/300/33",
               bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf); end
  endtask

  // One issue and one completion per cycle; each instruction commits two edges after issue.
  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 42; c++) begin
      if (c < 40) issue(32'h1000 + 32'(4 * c), 5'(c % 31 + 1));
      else no_issue();
      if (c >= 1 && c <= 40) cdb(32'h1000 + 32'(4 * (c - 1)), 32'h500 + 32'(c - 1), 1'b0, 32'h0);
      else no_cdb();
      step();
      if (c >= 2) begin
        checks++; if ({bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf}
                      !== {1'b1, 32'h1000 + 32'(4 * (c - 2)), 32'h500 + 32'(c - 2)}) begin
          errors++;
          $display("FAIL wrap c=%0d commit=%b pc=%h data=%h exp 1/%h/%h", c,
                   bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf,
                   32'h1000 + 32'(4 * (c - 2)), 32'h500 + 32'(c - 2)); end
      end else begin
        checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
          $display("FAIL wrap_start c=%0d got=%b exp=0", c, bus.is_commit_to_rf); end
      end
    end
    idle();
  endtask

  task automatic test_dup_tag();
    do_reset();
    issue(32'h20, 5'd1); step();
    issue(32'h20, 5'd2); step();
    no_issue();
    cdb(32'h20, 32'h5, 1'b0, 32'h0); step();
    no_cdb();
    step();
    checks++; if ({bus.is_commit_to_rf, bus.rd_to_rf, bus.data_to_rf}
                  !== {1'b1, 5'd1, 32'h5}) begin errors++;
      $display("FAIL dup_older commit=%b rd=%0d data=%h exp 1/1/5",
               bus.is_commit_to_rf, bus.rd_to_rf, bus.data_to_rf); end
    step();
    checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
      $display("FAIL dup_younger_not_ready got=%b rd=%0d exp=0",
               bus.is_commit_to_rf, bus.rd_to_rf); end
    cdb(32'h20, 32'h6, 1'b0, 32'h0); step();
    no_cdb();
    step();
    checks++; if ({bus.is_commit_to_rf, bus.rd_to_rf, bus.data_to_rf}
                  !== {1'b1, 5'd2, 32'h6}) begin errors++;
      $display("FAIL dup_younger commit=%b rd=%0d data=%h exp 1/2/6",
               bus.is_commit_to_rf, bus.rd_to_rf, bus.data_to_rf); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(32'h40 + 32'(4 * i), 5'(i + 9));
      step();
    end
    no_issue();
    cdb(32'h40, 32'hA, 1'b0, 32'h0); step();
    cdb(32'h44, 32'hB, 1'b0, 32'h0); step();
    no_cdb();
    checks++; if ({bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf}
                  !== {1'b1, 32'h40, 32'hA}) begin errors++;
      $display("FAIL ar_pre commit=%b pc=%h data=%h exp 1/40/a",
               bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf, bus.rd_to_rf,
                   bus.is_full_to_decoder} !== '0) begin errors++;
      $display("FAIL ar_immediate commit=%b pc=%h data=%h rd=%0d full=%b exp all 0",
               bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf, bus.rd_to_rf,
               bus.is_full_to_decoder); end
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cdb(32'h48 + 32'(4 * i), 32'hC, 1'b0, 32'h0);
      else no_cdb();
      step();
      checks++; if (bus.is_commit_to_rf !== 1'b0) begin errors++;
        $display("FAIL ar_after i=%0d pc=%h exp no commit", i, bus.pc_to_rf); end
    end
    issue(32'h80, 5'd4); step();
    no_issue();
    cdb(32'h80, 32'h88, 1'b0, 32'h0); step();
    no_cdb();
    step();
    checks++; if ({bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf}
                  !== {1'b1, 32'h80, 32'h88}) begin errors++;
      $display("FAIL ar_new commit=%b pc=%h data=%h exp 1/80/88",
               bus.is_commit_to_rf, bus.pc_to_rf, bus.data_to_rf); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle();
    test_reset();
    test_fill_and_retire();
    test_mispredict();
    test_wrap();
    test_dup_tag();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
